// File: rtl/ntt_addr_sched_pkg.sv
// Shared types, sizes and stage-mapping helpers for the NTT address scheduler.
package ntt_addr_sched_pkg;

  localparam int unsigned N_STAGES         = 11;
  localparam int unsigned P_MAX            = 10;
  localparam int unsigned TUPLES_PER_STAGE = 512;
  localparam int unsigned P_W              = 4;
  localparam int unsigned K_W              = 9;
  localparam int unsigned I_W              = 9;
  localparam int unsigned IDX_W            = 4;

  // One bit wider than the counters so 2^9 is representable before the -1.
  localparam logic [I_W:0] LIM_ONE = 10'd1;

  typedef enum logic [1:0] {StIdle, StRun, StGap, StFin} state_e;

  // Forward runs the special stage last; inverse runs it first.
  function automatic logic stage_is_special(input logic [IDX_W-1:0] idx, input logic inv);
    return inv ? (idx == '0) : (idx == IDX_W'(N_STAGES - 1));
  endfunction

  function automatic logic [P_W-1:0] stage_p(input logic [IDX_W-1:0] idx, input logic inv);
    logic [P_W-1:0] p;
    if (stage_is_special(idx, inv)) begin
      p = '0;
    end else if (inv) begin
      p = P_W'(idx);
    end else begin
      p = P_W'(P_MAX) - P_W'(idx);
    end
    return p;
  endfunction

  // Last in-group index: 2^(p-1)-1, or 0 in the special stage.
  function automatic logic [I_W-1:0] i_limit(input logic [P_W-1:0] p, input logic special);
    logic [I_W:0] lim;
    if (special) begin
      lim = '0;
    end else begin
      lim = (LIM_ONE << (p - P_W'(1))) - LIM_ONE;
    end
    return I_W'(lim);
  endfunction

  // Last group index: 2^(10-p)-1, or 511 in the special stage.
  function automatic logic [K_W-1:0] k_limit(input logic [P_W-1:0] p, input logic special);
    logic [I_W:0] lim;
    if (special) begin
      lim = (LIM_ONE << I_W) - LIM_ONE;
    end else begin
      lim = (LIM_ONE << (P_W'(P_MAX) - p)) - LIM_ONE;
    end
    return K_W'(lim);
  endfunction

endpackage

// File: rtl/ntt_stage_cnt.sv
// Nested k (outer) / i (inner) counter for one NTT stage; flags the stage's last tuple.
module ntt_stage_cnt
  import ntt_addr_sched_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           adv,
  input  logic [P_W-1:0] p,
  input  logic           special,
  output logic [K_W-1:0] k,
  output logic [I_W-1:0] i,
  output logic           last
);

  logic [K_W-1:0] k_q, k_d;
  logic [I_W-1:0] i_q, i_d;
  logic           last_q, last_d;
  logic [I_W-1:0] i_lim;
  logic [K_W-1:0] k_lim;

  // Next counter value; wrap points come from p, not from counter overflow.
  always_comb begin
    i_lim  = i_limit(p, special);
    k_lim  = k_limit(p, special);
    k_d    = k_q;
    i_d    = i_q;
    last_d = last_q;
    if (load) begin
      k_d    = '0;
      i_d    = '0;
      last_d = 1'b0;
    end else if (adv) begin
      if (i_q == i_lim) begin
        i_d = '0;
        k_d = k_q + K_W'(1);
      end else begin
        i_d = i_q + I_W'(1);
      end
      last_d = (i_d == i_lim) && (k_d == k_lim);
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q    <= '0;
      i_q    <= '0;
      last_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      i_q    <= i_d;
      last_q <= last_d;
    end
  end

  assign k    = k_q;
  assign i    = i_q;
  assign last = last_q;

endmodule

// File: rtl/ntt_addr_sched.sv
// NTT stage/tuple scheduler: sequences 11 stages of 512 (special_add, p, k, i) tuples.
module ntt_addr_sched
  import ntt_addr_sched_pkg::*;
#(
  parameter int unsigned STAGE_GAP = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           inv,
  input  logic           out_ready,
  output logic           out_valid,
  output logic           special_add,
  output logic [P_W-1:0] p,
  output logic [K_W-1:0] k,
  output logic [I_W-1:0] i,
  output logic           stage_last,
  output logic           busy,
  output logic           done
);

  // Wraps harmlessly when STAGE_GAP is 0; the gap state is never entered then.
  localparam logic [3:0] GAP_LAST = 4'(STAGE_GAP - 1);

  state_e           state_q, state_d;
  logic             inv_q, inv_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [P_W-1:0]   p_q, p_d;
  logic             sp_q, sp_d;
  logic [3:0]       gap_q, gap_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_load, cnt_adv;
  logic             hs;
  logic             cnt_last;

  assign hs      = valid_q & out_ready;
  assign idx_nxt = idx_q + IDX_W'(1);

  // Next-state, stage sequencing and registered-output next values.
  always_comb begin
    state_d  = state_q;
    inv_d    = inv_q;
    idx_d    = idx_q;
    p_d      = p_q;
    sp_d     = sp_q;
    gap_d    = gap_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_adv  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          inv_d    = inv;
          idx_d    = '0;
          p_d      = stage_p('0, inv);
          sp_d     = stage_is_special('0, inv);
          cnt_load = 1'b1;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (hs) begin
          if (!cnt_last) begin
            cnt_adv = 1'b1;
          end else if (idx_q == IDX_W'(N_STAGES - 1)) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = StFin;
          end else begin
            // Next stage is loaded now so it is ready when the gap ends.
            idx_d    = idx_nxt;
            p_d      = stage_p(idx_nxt, inv_q);
            sp_d     = stage_is_special(idx_nxt, inv_q);
            cnt_load = 1'b1;
            gap_d    = '0;
            if (STAGE_GAP != 0) begin
              valid_d = 1'b0;
              state_d = StGap;
            end
          end
        end
      end
      StGap: begin
        if (gap_q == GAP_LAST) begin
          valid_d = 1'b1;
          state_d = StRun;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      StFin: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any transform in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      inv_q   <= 1'b0;
      idx_q   <= '0;
      p_q     <= '0;
      sp_q    <= 1'b0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      idx_q   <= idx_d;
      p_q     <= p_d;
      sp_q    <= sp_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  ntt_stage_cnt u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .adv     (cnt_adv),
    .p       (p_q),
    .special (sp_q),
    .k       (k),
    .i       (i),
    .last    (cnt_last)
  );

  assign out_valid   = valid_q;
  assign special_add = sp_q;
  assign p           = p_q;
  assign stage_last  = cnt_last;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
